pattern_detector_mealy: RTL and testbench

//  Parametrised serial pattern recogniser: Mealy output y pulses combinationally on the input bit that completes PATTERN.

---
 rtl/pattern_detector_mealy_pkg.sv | 45 ++++
 rtl/pattern_detector_mealy_if.sv | 15 +
 rtl/pattern_detector_mealy_sat_counter.sv | 27 ++
 rtl/pattern_detector_mealy.sv | 65 ++++++
 tb/tb_pattern_detector_mealy.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_detector_mealy_pkg.sv
// pattern_det_pkg: elaboration-time helpers that build the KMP transition table for the detector
package pattern_det_pkg;

    localparam int MAX_PAT_W = 16;

    function automatic logic bit_of(input logic [31:0] v, input int idx);
        return v[idx[4:0]];
    endfunction

    // Returns the length of the longest PATTERN prefix that is a suffix of (prefix_s, a).
    // A result of pat_w means the pattern has just completed. Rows beyond the legal
    // state range return 0 so that unused encodings fall back to the idle state.
    function automatic int next_state(input logic [31:0] pattern, input int pat_w, input int s, input logic a);
        logic [31:0] c;
        logic ok;
        int best;
        if (s < 0 || s >= pat_w) return 0;
        c = '0;
        for (int j = 0; j < s; j++) c = c | (32'(bit_of(pattern, pat_w - 1 - j)) << j);
        c = c | (32'(a) << s);
        best = 0;
        for (int k = 1; k <= s + 1; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++)
                if (bit_of(pattern, pat_w - 1 - i) != bit_of(c, s + 1 - k + i)) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

    // Length of the longest proper border: where the search resumes after an overlapping match.
    function automatic int border_len(input logic [31:0] pattern, input int pat_w);
        logic ok;
        int best;
        best = 0;
        for (int b = 1; b < pat_w; b++) begin
            ok = 1'b1;
            for (int i = 0; i < b; i++)
                if (bit_of(pattern, pat_w - 1 - i) != bit_of(pattern, b - 1 - i)) ok = 1'b0;
            if (ok) best = b;
        end
        return best;
    endfunction

endpackage

// File: rtl/pattern_detector_mealy_if.sv
// pattern_detector_mealy_if: serial stream inputs and match/count outputs of the detector
interface pattern_detector_mealy_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             a;
    logic             overlap;
    logic             clear;
    logic             y;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (output en, a, overlap, clear, input y, match_count, count_sat);
    modport slave (input en, a, overlap, clear, output y, match_count, count_sat);
endinterface

// File: rtl/pattern_detector_mealy_sat_counter.sv
// sat_counter: match counter that freezes at all-ones and raises a sticky saturation flag
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    // count increments stop at all-ones; sat is set on the increment that reaches it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
            sat   <= &(count + 1'b1);
        end
    end

endmodule

// File: rtl/pattern_detector_mealy.sv
// pattern_detector_mealy: parametrised Mealy serial pattern recogniser with overlap mode and match counter
module pattern_detector_mealy
    import pattern_det_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input logic                     clk,
    input logic                     reset,
    pattern_detector_mealy_if.slave bus
);

    localparam int SW   = $clog2(PAT_W);
    localparam int KW   = $clog2(PAT_W + 1);
    localparam int ROWS = 2 ** SW;
    localparam logic [SW-1:0] OVL = SW'(border_len(32'(PATTERN), PAT_W));
    localparam logic [KW-1:0] HIT = KW'(PAT_W);
    localparam logic [SW:0]   LIM = (SW + 1)'(PAT_W);

    typedef logic [SW-1:0] state_t;

    logic [KW-1:0] tab [ROWS][2];
    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic          legal;
    logic          hit;

    for (genvar s = 0; s < ROWS; s++) begin : g_row
        for (genvar v = 0; v < 2; v++) begin : g_col
            localparam int NS = next_state(32'(PATTERN), PAT_W, s, v == 1);
            assign tab[s][v] = KW'(NS);
        end
    end

    // table lookup, match strobe and next-state selection; clear beats en, illegal states fall to 0
    always_comb begin
        k         = tab[state][bus.a];
        legal     = {1'b0, state} < LIM;
        hit       = bus.en && !bus.clear && !reset && legal && k == HIT;
        state_nxt = (bus.clear || !legal) ? '0
                  : !bus.en ? state
                  : hit ? (bus.overlap ? OVL : '0)
                  : SW'(k);
    end

    // search state register; reset discards any partial progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= '0;
        else state <= state_nxt;
    end

    assign bus.y = hit;

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clear(bus.clear),
        .count(bus.match_count),
        .sat  (bus.count_sat)
    );

endmodule

// File: tb/tb_pattern_detector_mealy.sv
// tb_pattern_detector_mealy: scenario tasks with a y/count scoreboard over three detector configurations
module tb_pattern_detector_mealy;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic a = 1'b0;
    logic overlap = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   fails = 0;
    logic exp_y_q[$];
    int   exp_cnt_q[$];

    always #5 clk = ~clk;

    pattern_detector_mealy_if #(.CNT_W(8)) b1 ();
    pattern_detector_mealy_if #(.CNT_W(2)) b2 ();
    pattern_detector_mealy_if #(.CNT_W(8)) b3 ();

    assign {b1.en, b1.a, b1.overlap, b1.clear} = {en, a, overlap, clear};
    assign {b2.en, b2.a, b2.overlap, b2.clear} = {en, a, overlap, clear};
    assign {b3.en, b3.a, b3.overlap, b3.clear} = {en, a, overlap, clear};

    pattern_detector_mealy dut1 (.clk(clk), .reset(reset), .bus(b1));
    pattern_detector_mealy #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    pattern_detector_mealy #(.PAT_W(6), .PATTERN(6'b101101)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    task automatic drive(input logic va, input logic ven, input logic ey);
        a = va;
        en = ven;
        exp_y_q.push_back(ey);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        en = 1'b1;
        a = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_reset();
        a = 1'b1;
        en = 1'b1;
        #2;
        checks += 5;
        if (b1.y !== 1'b0) begin fails++; $display("FAIL reset_y: got %b expected 0", b1.y); end
        if (b1.match_count !== 8'd0) begin fails++; $display("FAIL reset_count1: got %0d expected 0", b1.match_count); end
        if (b1.count_sat !== 1'b0) begin fails++; $display("FAIL reset_sat1: got %b expected 0", b1.count_sat); end
        if (b2.match_count !== 2'd0) begin fails++; $display("FAIL reset_count2: got %0d expected 0", b2.match_count); end
        if (b3.match_count !== 8'd0) begin fails++; $display("FAIL reset_count3: got %0d expected 0", b3.match_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1101101;
        logic [6:0] m = 7'b0001001;
        logic ey;
        int ec;
        do_clear();
        overlap = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            drive(s[6], 1'b1, m[6]);
            #2;
            ey = exp_y_q.pop_front();
            checks++;
            if (b1.y !== ey) begin fails++; $display("FAIL overlap_y bit %0d: got %b expected %b", n, b1.y, ey); end
            @(posedge clk); #1;
            s = s << 1;
            m = m << 1;
        end
        en = 1'b0;
        exp_cnt_q.push_back(2);
        ec = exp_cnt_q.pop_front();
        checks++;
        if (b1.match_count !== 8'(ec)) begin fails++; $display("FAIL overlap_count: got %0d expected %0d", b1.match_count, ec); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1101101;
        logic [6:0] m = 7'b0001000;
        logic ey;
        int ec;
        do_clear();
        overlap = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            drive(s[6], 1'b1, m[6]);
            #2;
            ey = exp_y_q.pop_front();
            checks++;
            if (b1.y !== ey) begin fails++; $display("FAIL nonoverlap_y bit %0d: got %b expected %b", n, b1.y, ey); end
            @(posedge clk); #1;
            s = s << 1;
            m = m << 1;
        end
        en = 1'b0;
        exp_cnt_q.push_back(1);
        ec = exp_cnt_q.pop_front();
        checks++;
        if (b1.match_count !== 8'(ec)) begin fails++; $display("FAIL nonoverlap_count: got %0d expected %0d", b1.match_count, ec); end
    endtask

    task automatic test_enable_gap();
        logic [7:0] sa = 8'b11010011;
        logic [7:0] se = 8'b11000111;
        logic [7:0] sm = 8'b00000010;
        logic ey;
        int ec;
        do_clear();
        overlap = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            drive(sa[7], se[7], sm[7]);
            #2;
            ey = exp_y_q.pop_front();
            checks++;
            if (b1.y !== ey) begin fails++; $display("FAIL gap_y cycle %0d: got %b expected %b", n, b1.y, ey); end
            @(posedge clk); #1;
            sa = sa << 1;
            se = se << 1;
            sm = sm << 1;
        end
        en = 1'b0;
        exp_cnt_q.push_back(1);
        ec = exp_cnt_q.pop_front();
        checks++;
        if (b1.match_count !== 8'(ec)) begin fails++; $display("FAIL gap_count: got %0d expected %0d", b1.match_count, ec); end
    endtask

    task automatic test_clear();
        logic ey;
        drive(1'b0, 1'b1, 1'b0);
        #2;
        ey = exp_y_q.pop_front();
        checks++;
        if (b1.y !== ey) begin fails++; $display("FAIL clear_pre_y: got %b expected %b", b1.y, ey); end
        @(posedge clk); #1;
        clear = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        #2;
        ey = exp_y_q.pop_front();
        checks++;
        if (b1.y !== ey) begin fails++; $display("FAIL clear_y: got %b expected %b", b1.y, ey); end
        @(posedge clk); #1;
        clear = 1'b0;
        checks += 2;
        if (b1.match_count !== 8'd0) begin fails++; $display("FAIL clear_count: got %0d expected 0", b1.match_count); end
        if (b1.count_sat !== 1'b0) begin fails++; $display("FAIL clear_sat: got %b expected 0", b1.count_sat); end
        drive(1'b1, 1'b1, 1'b0);
        #2;
        ey = exp_y_q.pop_front();
        checks++;
        if (b1.y !== ey) begin fails++; $display("FAIL clear_post_y: got %b expected %b", b1.y, ey); end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] s;
        logic [3:0] m;
        logic ey;
        int ec;
        do_clear();
        overlap = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            s = 4'b1101;
            m = 4'b0001;
            for (int n = 1; n <= 4; n++) begin
                drive(s[3], 1'b1, m[3]);
                #2;
                ey = exp_y_q.pop_front();
                checks++;
                if (b2.y !== ey) begin fails++; $display("FAIL sat_y rep %0d bit %0d: got %b expected %b", r, n, b2.y, ey); end
                @(posedge clk); #1;
                s = s << 1;
                m = m << 1;
            end
            exp_cnt_q.push_back(r > 3 ? 3 : r);
            ec = exp_cnt_q.pop_front();
            checks += 2;
            if (b2.match_count !== 2'(ec)) begin fails++; $display("FAIL sat_count rep %0d: got %0d expected %0d", r, b2.match_count, ec); end
            if (b2.count_sat !== (ec == 3)) begin fails++; $display("FAIL sat_flag rep %0d: got %b expected %b", r, b2.count_sat, ec == 3); end
        end
        en = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks += 2;
        if (b2.match_count !== 2'd0) begin fails++; $display("FAIL sat_clear_count: got %0d expected 0", b2.match_count); end
        if (b2.count_sat !== 1'b0) begin fails++; $display("FAIL sat_clear_flag: got %b expected 0", b2.count_sat); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] p = 3'b110;
        logic [3:0] s = 4'b1101;
        logic [3:0] m = 4'b0001;
        logic ey;
        int ec;
        do_clear();
        overlap = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            drive(p[2], 1'b1, 1'b0);
            #2;
            ey = exp_y_q.pop_front();
            checks++;
            if (b1.y !== ey) begin fails++; $display("FAIL rstmid_pre_y bit %0d: got %b expected %b", n, b1.y, ey); end
            @(posedge clk); #1;
            p = p << 1;
        end
        a = 1'b1;
        en = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (b1.y !== 1'b0) begin fails++; $display("FAIL rstmid_y_in_reset: got %b expected 0", b1.y); end
        #1;
        reset = 1'b0;
        en = 1'b0;
        @(posedge clk); #1;
        for (int n = 1; n <= 4; n++) begin
            drive(s[3], 1'b1, m[3]);
            #2;
            ey = exp_y_q.pop_front();
            checks++;
            if (b1.y !== ey) begin fails++; $display("FAIL rstmid_y bit %0d: got %b expected %b", n, b1.y, ey); end
            @(posedge clk); #1;
            s = s << 1;
            m = m << 1;
        end
        en = 1'b0;
        exp_cnt_q.push_back(1);
        ec = exp_cnt_q.pop_front();
        checks++;
        if (b1.match_count !== 8'(ec)) begin fails++; $display("FAIL rstmid_count: got %0d expected %0d", b1.match_count, ec); end
    endtask

    task automatic test_border6();
        logic [8:0] s = 9'b101101101;
        logic [8:0] m = 9'b000001001;
        logic ey;
        int ec;
        do_clear();
        overlap = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            drive(s[8], 1'b1, m[8]);
            #2;
            ey = exp_y_q.pop_front();
            checks++;
            if (b3.y !== ey) begin fails++; $display("FAIL border6_y bit %0d: got %b expected %b", n, b3.y, ey); end
            @(posedge clk); #1;
            s = s << 1;
            m = m << 1;
        end
        en = 1'b0;
        exp_cnt_q.push_back(2);
        ec = exp_cnt_q.pop_front();
        checks++;
        if (b3.match_count !== 8'(ec)) begin fails++; $display("FAIL border6_count: got %0d expected %0d", b3.match_count, ec); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_enable_gap();
        test_clear();
        test_saturation();
        test_reset_mid();
        test_border6();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
